// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a sticky overflow flag.
// Stores to TX_ADDR enqueue a byte; STAT_ADDR reads {ovf, full, empty, busy}.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0104,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovf_q, ovf_d;

  logic empty, full, bit_done, pop, push_req, push, ovf_event, ovf_clr;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign bit_done = (timer_q == TW'(CLKS_PER_BIT - 1));

  // The FSM pops either from idle or at the last cycle of a stop bit (back-to-back frames).
  assign pop       = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
  assign push_req  = memwrite && (dataadr == TX_ADDR);
  assign push      = push_req && (!full || pop);
  assign ovf_event = push_req && !push;
  assign ovf_clr   = memwrite && (dataadr == STAT_ADDR) && writedata[0];

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A same-edge overflow wins over a clear.
    ovf_d = ovf_event ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!empty) begin
          state_d = StStart;
          shift_d = mem[rptr_q];
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          timer_d   = '0;
          bit_cnt_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d   = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          timer_d = '0;
          if (!empty) begin
            state_d = StStart;
            shift_d = mem[rptr_q];
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= writedata[7:0];
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (state_q != StIdle) || !empty;
  assign readdata = (dataadr == STAT_ADDR) ? {28'b0, ovf_q, full, empty, busy} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-schedule model predicts tx, busy and status every cycle.
// Each accepted byte is modelled by its push edge, its pop edge and its data.
module tb_mmio_uart_tx;

  localparam logic [31:0] TXA   = 32'h0000_0100;
  localparam logic [31:0] STA   = 32'h0000_0104;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = STA;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         acc_p[$];
  int         acc_s[$];
  logic [7:0] acc_d[$];
  int         last_s = -1000000;
  logic       m_ovf = 1'b0;
  bit         m_ov;
  int         m_s;
  int         m_cnt;
  logic       m_busy;
  logic [31:0] m_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bytes in the FIFO after edge e (strict: before this edge's push, after its pop).
  function automatic int fifo_cnt(input int e, input bit strict);
    int n = 0;
    for (int i = 0; i < acc_p.size(); i++) begin
      if ((strict ? acc_p[i] < e : acc_p[i] <= e) && acc_s[i] > e) n++;
    end
    return n;
  endfunction

  function automatic bit frame_active(input int e);
    for (int i = 0; i < acc_s.size(); i++) begin
      if (acc_s[i] <= e && e < acc_s[i] + FRAME) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_tx(input int e);
    int k, b;
    for (int i = 0; i < acc_s.size(); i++) begin
      k = e - acc_s[i];
      if (k >= 0 && k < FRAME) begin
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return acc_d[i][b-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      acc_p.delete();
      acc_s.delete();
      acc_d.delete();
      last_s = -1000000;
      m_ovf  = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (memwrite && dataadr == TXA) begin
        if (fifo_cnt(cyc, 1'b1) < DEPTH) begin
          m_s = (cyc + 1 > last_s + FRAME) ? cyc + 1 : last_s + FRAME;
          acc_p.push_back(cyc);
          acc_s.push_back(m_s);
          acc_d.push_back(writedata[7:0]);
          last_s = m_s;
        end else begin
          m_ov = 1'b1;
        end
      end
      if (m_ov) m_ovf = 1'b1;
      else if (memwrite && dataadr == STA && writedata[0]) m_ovf = 1'b0;
    end
    #1;
    m_cnt  = fifo_cnt(cyc, 1'b0);
    m_busy = frame_active(cyc) || (m_cnt > 0);
    m_rd   = (dataadr == STA) ?
             {28'b0, m_ovf, m_cnt == DEPTH, m_cnt == 0, m_busy} : 32'h0;
    check_eq("tx", tx, exp_tx(cyc));
    check_eq("busy", busy, m_busy);
    check_eq("readdata", readdata, m_rd);
  end

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    memwrite = 1'b0;
    dataadr  = STA;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    memwrite = 1'b0;
    dataadr  = STA;
    while ((frame_active(cyc) || fifo_cnt(cyc, 1'b0) > 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check_eq("idle_timeout", busy, 32'h0);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check_eq("wait_timeout", cyc, target);
  endtask

  int first;
  int r;

  initial begin
    repeat (3) @(negedge clk);
    // Push lands on the very first edge after release.
    memwrite  = 1'b1;
    dataadr   = TXA;
    writedata = 32'h0000_0022;
    reset     = 1'b1;
    @(negedge clk);
    idle(1);
    wait_idle();
    idle(3);

    for (int i = 0; i < 6; i++) drive(1'b1, TXA, 32'h41 + i);
    idle(170);
    check_eq("ovf_status", readdata, 32'h9);
    drive(1'b1, STA, 32'h0);
    check_eq("ovf_keep", readdata, 32'h9);
    drive(1'b1, STA, 32'h1);
    check_eq("ovf_clear", readdata, 32'h1);
    wait_idle();

    drive(1'b1, 32'h0000_0054, 32'h5A);
    drive(1'b0, TXA, 32'h5A);
    check_eq("dec_rd", readdata, 32'h0);
    check_eq("dec_tx", tx, 32'h1);
    check_eq("dec_busy", busy, 32'h0);
    idle(5);

    // Full FIFO, push on the edge that ends the stop bit.
    wait_idle();
    first = acc_s.size();
    for (int i = 0; i < 5; i++) drive(1'b1, TXA, 32'h90 + i);
    idle(1);
    check_eq("pp_full", readdata, 32'h5);
    wait_cyc(acc_s[first] + FRAME - 1);
    drive(1'b1, TXA, 32'h99);
    idle(1);
    check_eq("pp_status", readdata, 32'h5);
    wait_idle();

    // Async reset during data bit 3 of 0x55 with two bytes queued.
    first = acc_s.size();
    drive(1'b1, TXA, 32'h55);
    drive(1'b1, TXA, 32'hAA);
    drive(1'b1, TXA, 32'h0F);
    idle(1);
    wait_cyc(acc_s[first] + 4 * CPB + 5);
    check_eq("pre_rst_tx", tx, 32'h0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_tx", tx, 32'h1);
    check_eq("rst_async_busy", busy, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(200);
    check_eq("rst_status", readdata, 32'h2);

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      drive(1'b1, TXA, $urandom);
      else if (r < 25) drive(1'b1, STA, $urandom);
      else if (r < 28) drive(1'b1, 32'h0000_0054, $urandom);
      else             drive(1'b0, ($urandom_range(0, 1) != 0) ? STA : TXA, $urandom);
    end
    wait_idle();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter TX_ADDR, default 32'h0000_0100; store address of the transmit-data register.
REQ-002 Parameter STAT_ADDR, default 32'h0000_0104; address of the status register.
REQ-003 Parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 2..65535.
REQ-004 Parameter FIFO_DEPTH, default 4; transmit FIFO entries, power of two, 2..16.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 memwrite  input  1  processor store strobe, sampled on rising clk.
REQ-008 dataadr  input  32  processor data address (byte address).
REQ-009 writedata  input  32  processor store data.
REQ-010 readdata  output  32  status read data, combinational from dataadr.
REQ-011 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 A push SHALL occur on a rising clk edge when memwrite=1 and dataadr==TX_ADDR; the pushed byte is writedata[7:0], and writedata[31:8] are ignored.
REQ-014 A push while the FIFO is full (count==FIFO_DEPTH after any same-edge pop) SHALL be dropped and SHALL set sticky bit ovf.
REQ-015 A store to STAT_ADDR with writedata[0]=1 SHALL clear ovf; a store with writedata[0]=0 SHALL have no effect.
REQ-016 If an overflow and a clear occur on the same edge, ovf SHALL end up set.
REQ-017 When dataadr==STAT_ADDR, readdata SHALL be {28'b0, ovf, full, empty, busy}; otherwise readdata SHALL be 32'b0.
REQ-018 The transmit FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-019 IDLE: tx=1. If the FIFO is non-empty at a rising edge, the FSM SHALL pop the head into the shift register on that edge and enter START.
REQ-020 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-021 DATA: tx=shift[0]. Each bit SHALL last CLKS_PER_BIT cycles and the register SHALL shift right after each bit; after the 8th bit the FSM SHALL enter STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles. If the FIFO is non-empty at the end of STOP, the FSM SHALL pop and enter START directly; otherwise it SHALL enter IDLE.
REQ-023 Frame length SHALL be 10*CLKS_PER_BIT cycles, and back-to-back frames SHALL have no idle gap.
REQ-024 A push and a pop on the same edge SHALL both take effect and leave count unchanged; a push into an empty FIFO in IDLE SHALL be popped on the following edge (1-cycle latency to the tx falling edge).
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 The full and empty flags SHALL be derived from a count of width log2(FIFO_DEPTH)+1, so that full and empty are never both true.
REQ-027 The bit timer SHALL count 0..CLKS_PER_BIT-1 and reload to 0 on every bit boundary.

Reset
REQ-028 While reset=0, outputs SHALL be tx=1 and busy=0, and readdata SHALL reflect empty=1, full=0, ovf=0.
REQ-029 While reset=0, the FSM SHALL be in IDLE, the FIFO pointers and count SHALL be 0, and the bit timer and shift register SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard all queued bytes; no partial frame SHALL resume after release.
REQ-031 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 Single byte: store 32'h0000_0022 to TX_ADDR -> tx falls 1 cycle later, stays low 16 cycles, then sends bits 0,1,0,0,0,1,0,0 (16 cycles each), then stop high; busy=0 at 160 cycles after the falling edge.
REQ-033 Overflow: 6 consecutive-cycle stores 0x41..0x46 to TX_ADDR from idle -> frames 0x41..0x45 transmitted back-to-back, 0x46 dropped, status read = 32'h0000_0009 during transmission (ovf=1, busy=1).
REQ-034 Overflow clear: after REQ-033, store 32'h1 to STAT_ADDR -> ovf=0; a store of 32'h0 to STAT_ADDR leaves ovf unchanged.
REQ-035 Address decode: store to 32'h0000_0054 or to TX_ADDR with memwrite=0 -> no push, tx stays 1, readdata=0.
REQ-036 Reset mid-frame: assert reset=0 during DATA bit 3 of 0x55 with 2 bytes queued -> tx=1 within the same cycle; after release the line stays idle and status = 32'h0000_0002.
REQ-037 Simultaneous push/pop: with FIFO full, push on the edge that ends STOP -> push accepted, ovf stays 0, count stays FIFO_DEPTH.
